// File: rtl/rf_read_arbiter_if.sv
// Bundle of signals between the register-file read arbiter and its users:
// requester handshake, read-mux select/data, write-forwarding and responses.
interface rf_read_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 16,
  parameter int AW   = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ-1:0]    req_ready;
  logic               port_en;
  logic [AW-1:0]      rf_sel;
  logic [DW-1:0]      rf_rdata;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;

  // Requesters, register file and write path as seen from outside the arbiter
  modport master (
    output req_valid, req_addr, port_en, rf_rdata, wr_en, wr_addr, wr_data,
    input  req_ready, rf_sel, rsp_valid, rsp_data
  );

  // The arbiter itself
  modport slave (
    input  req_valid, req_addr, port_en, rf_rdata, wr_en, wr_addr, wr_data,
    output req_ready, rf_sel, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing the single register-file read port between
// NREQ requesters. Grants are combinational, responses are registered with
// exactly one cycle of latency, and a same-cycle write is forwarded.
module rf_read_arbiter #(
  parameter int NREQ    = 3,
  parameter int DW      = 16,
  parameter int AW      = 4,
  parameter int ZERO_R0 = 1
) (
  input logic              clk,
  input logic              rst_n,
  rf_read_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);

  logic [AW-1:0]   addr_arr [NREQ];
  logic [PW-1:0]   ptr_reg;
  logic [PW-1:0]   ptr_next;
  logic [NREQ-1:0] grant_vec;
  logic [PW-1:0]   grant_idx;
  logic            grant_any;
  logic [AW-1:0]   grant_addr;
  logic [DW-1:0]   read_val;
  logic [NREQ-1:0] rsp_valid_reg;
  logic [DW-1:0]   rsp_data_reg;

  // Unpack the flat address bus into one address per requester
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
      assign addr_arr[gi] = bus.req_addr[gi*AW +: AW];
    end
  endgenerate

  // Search upward from the pointer (wrapping) for the first valid requester;
  // nothing is granted while the port is stolen or reset is asserted
  always_comb begin
    int idx;
    idx        = 0;
    grant_vec  = '0;
    grant_idx  = '0;
    grant_any  = 1'b0;
    grant_addr = '0;
    if (rst_n && bus.port_en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr_reg) + k;
        if (idx >= NREQ) idx = idx - NREQ;
        if (!grant_any && bus.req_valid[idx]) begin
          grant_any      = 1'b1;
          grant_idx      = PW'(idx);
          grant_vec[idx] = 1'b1;
          grant_addr     = addr_arr[idx];
        end
      end
    end
  end

  // Register 0 reads as zero, then a same-cycle write wins over the mux output
  always_comb begin
    if ((ZERO_R0 != 0) && (grant_addr == '0))
      read_val = '0;
    else if (bus.wr_en && (bus.wr_addr == grant_addr))
      read_val = bus.wr_data;
    else
      read_val = bus.rf_rdata;
  end

  // Pointer moves just past the granted requester, holds when idle
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any)
      ptr_next = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Pointer and response registers; reset drops any in-flight response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      rsp_valid_reg <= '0;
      rsp_data_reg  <= '0;
    end else begin
      ptr_reg       <= ptr_next;
      rsp_valid_reg <= grant_vec;
      if (grant_any)
        rsp_data_reg <= read_val;
    end
  end

  assign bus.req_ready = grant_vec;
  assign bus.rf_sel    = grant_addr;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter: a simple register-file model drives the
// read mux, expected responses are queued at grant time and checked when the
// response cycle arrives.
module tb_rf_read_arbiter;
  logic clk;
  logic rst_n;
  logic [15:0] regs [16];

  typedef struct packed {
    logic [2:0]  g;
    logic [15:0] d;
  } exp_t;

  exp_t        sb [$];
  int          n_tests;
  int          n_fail;
  logic [15:0] last_data;

  rf_read_arbiter_if #(.NREQ(3), .DW(16), .AW(4)) bus ();

  rf_read_arbiter #(.NREQ(3), .DW(16), .AW(4), .ZERO_R0(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Combinational 16:1 read mux of the modelled register bank
  assign bus.rf_rdata = regs[bus.rf_sel];

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Response side of a cycle: pop the scoreboard or expect an idle response
  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(e.g));
      check({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(e.d));
      last_data = e.d;
    end else begin
      check({tag, "_rsp_idle"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_rsp_hold"}, 32'(bus.rsp_data), 32'(last_data));
    end
  endtask

  // One cycle: inputs already driven; check grant/select, queue the expected
  // response, clock, then check the response.
  task automatic step(input logic [2:0] eg, input logic [3:0] es,
                      input logic [15:0] ed, input string tag);
    exp_t e;
    #1;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(eg));
    check({tag, "_sel"}, 32'(bus.rf_sel), 32'(es));
    if (eg != 3'b000) begin
      e.g = eg;
      e.d = ed;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    $display("[TB] %s: req_ready=%b rf_sel=%h -> rsp_valid=%b rsp_data=%h",
             tag, eg, es, bus.rsp_valid, bus.rsp_data);
    check_rsp(tag);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.wr_en     = 1'b0;
    bus.port_en   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    last_data = '0;
  endtask

  // Grant in this cycle, then assert reset in the response cycle
  task automatic mid_reset(input logic [2:0] eg, input logic [3:0] es, input string tag);
    #1;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(eg));
    check({tag, "_sel"}, 32'(bus.rf_sel), 32'(es));
    @(posedge clk);
    #1;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    #1;
    check({tag, "_rst_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rst_data"}, 32'(bus.rsp_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    last_data = '0;
    @(posedge clk);
    #1;
    $display("[TB] %s: reset during response, rsp_valid=%b rsp_data=%h",
             tag, bus.rsp_valid, bus.rsp_data);
    check({tag, "_post_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_post_data"}, 32'(bus.rsp_data), 32'd0);
  endtask

  initial begin
    logic [2:0]  rr_g [3];
    logic [15:0] rr_d [3];
    n_tests   = 0;
    n_fail    = 0;
    last_data = '0;
    for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.port_en   = 1'b1;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;

    // Reset: requests are ignored while rst_n is low
    bus.req_valid = 3'b111;
    #2;
    check("rst_ready_in_reset", 32'(bus.req_ready), 32'd0);
    check("rst_valid_in_reset", 32'(bus.rsp_valid), 32'd0);
    check("rst_data_in_reset", 32'(bus.rsp_data), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.req_valid = '0;
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_sel", 32'(bus.rf_sel), 32'd0);
    @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_data", 32'(bus.rsp_data), 32'd0);
    $display("[TB] reset: rsp_valid=%b rsp_data=%h", bus.rsp_valid, bus.rsp_data);

    // Single request from requester 1 for R5
    regs[5]       = 16'h1234;
    bus.req_addr  = {4'd0, 4'd5, 4'd0};
    bus.req_valid = 3'b010;
    step(3'b010, 4'd5, 16'h1234, "single");
    bus.req_valid = 3'b000;
    step(3'b000, 4'd0, 16'h0000, "idle");

    // Round robin from pointer 0, all requesters valid, back-to-back grants
    do_reset();
    regs[1] = 16'h1111;
    regs[2] = 16'h2222;
    regs[3] = 16'h3333;
    rr_g = '{3'b001, 3'b010, 3'b100};
    rr_d = '{16'h1111, 16'h2222, 16'h3333};
    bus.req_addr  = {4'd3, 4'd2, 4'd1};
    bus.req_valid = 3'b111;
    for (int i = 0; i < 6; i++)
      step(rr_g[i % 3], 4'(i % 3 + 1), rr_d[i % 3], $sformatf("rr%0d", i));

    // Write forwarding on requester 0 (pointer is back at 0)
    regs[7]       = 16'h00AA;
    bus.req_addr  = {4'd3, 4'd2, 4'd7};
    bus.req_valid = 3'b001;
    bus.wr_en     = 1'b1;
    bus.wr_addr   = 4'd7;
    bus.wr_data   = 16'hBEEF;
    step(3'b001, 4'd7, 16'hBEEF, "fwd_hit");
    bus.wr_addr   = 4'd6;
    step(3'b001, 4'd7, 16'h00AA, "fwd_miss");

    // R0 reads zero over both the mux and a forwarded write
    regs[0]       = 16'hFFFF;
    bus.req_addr  = {4'd3, 4'd2, 4'd0};
    bus.wr_addr   = 4'd0;
    bus.wr_data   = 16'h5555;
    step(3'b001, 4'd0, 16'h0000, "r0_zero");
    bus.wr_en     = 1'b0;

    // Port stolen for two cycles: no grant, pointer (now 1) must hold
    regs[9]       = 16'h9999;
    regs[10]      = 16'hAAAA;
    bus.req_addr  = {4'd9, 4'd10, 4'd3};
    bus.port_en   = 1'b0;
    bus.req_valid = 3'b100;
    step(3'b000, 4'd0, 16'h0000, "stall0");
    step(3'b000, 4'd0, 16'h0000, "stall1");
    bus.port_en   = 1'b1;
    bus.req_valid = 3'b110;
    step(3'b010, 4'd10, 16'hAAAA, "after_stall");

    // Grant requester 2, then reset during its response cycle
    bus.req_valid = 3'b100;
    mid_reset(3'b100, 4'd9, "midrst2");

    // Move the pointer to 1 via a grant to requester 0, reset, confirm pointer 0
    bus.req_valid = 3'b001;
    mid_reset(3'b001, 4'd3, "midrst0");
    bus.req_valid = 3'b111;
    step(3'b001, 4'd3, 16'h3333, "ptr_after_rst");
    bus.req_valid = 3'b000;
    step(3'b000, 4'd0, 16'h0000, "final_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_read_arbiter.md
Name: rf_read_arbiter

Overview:
- Shares the single register-file read port (the 16-entry, 16-bit register bank read through the 16:1 select mux) between several requesters, e.g. decode rs1, decode rs2 and the debug port.
- Round-robin arbitration with a valid/ready request handshake and a registered, one-cycle-latency response per requester.
- Drives the mux select and captures the mux output.
- Forwards a same-cycle register write so a reader never sees stale data.

Parameters:
- NREQ, 3, number of requesters (2..8)
- DW, 16, register data width
- AW, 4, register address width (16 registers)
- ZERO_R0, 1, when 1 reads of register 0 return 0 regardless of mux output and write forwarding

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester read request
- req_addr  input  NREQ*AW  per-requester register address; requester i uses bits [i*AW +: AW]
- req_ready  output  NREQ  one-hot grant; a request is accepted when valid and ready are both high on a clock edge
- port_en  input  1  when 0, no grant is issued this cycle (port stolen, e.g. by test access)
- rf_sel  output  AW  select to the 16:1 read mux
- rf_rdata  input  DW  read mux output, combinationally valid for rf_sel in the same cycle
- wr_en  input  1  register-file write strobe, effective this cycle
- wr_addr  input  AW  write address
- wr_data  input  DW  write data
- rsp_valid  output  NREQ  one-hot, registered; bit i high for exactly one cycle per accepted request of requester i
- rsp_data  output  DW  registered read result, valid when any rsp_valid bit is high

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid=0, rsp_data=0, round-robin pointer=0. req_ready is combinational and forced to 0 while rst_n is low.
- A response in flight at reset assertion is discarded; no rsp_valid is produced after reset release.
- Arbitration (combinational, each cycle):
  - If port_en=1 and any req_valid is set, grant the first valid requester searching upward from the pointer, wrapping NREQ-1 -> 0.
  - req_ready is the one-hot grant; all bits are 0 if no request or port_en=0.
  - req_ready does not depend on rsp state, so back-to-back grants every cycle are allowed.
- Pointer: on a clock edge with a grant to requester g, the pointer becomes (g+1) mod NREQ. With no grant the pointer holds.
- rf_sel = req_addr of the granted requester; 0 when there is no grant.
- Read value selection, in priority order:
  - ZERO_R0=1 and address 0 -> 0.
  - Else wr_en=1 and wr_addr equals the granted address -> wr_data (write forwarding).
  - Else rf_rdata.
- Latency: accepted at edge N; rsp_valid[g]=1 and rsp_data=value in the cycle following edge N. Exactly 1 cycle.
- Idle cycle after a grant: rsp_valid returns to 0 and rsp_data holds its last value.
- Requester behaviour while waiting: a requester holds req_valid and req_addr until it sees req_ready. Changing req_addr while not granted is legal; the address sampled at the accepting edge is the one used.
- Only one request is accepted per cycle, so at most one rsp_valid bit is ever set.
- Starvation bound: with every requester asserting continuously, each is granted at least once every NREQ cycles in which port_en=1.
- port_en=0: no grant, pointer holds. A response already registered still appears on the next cycle.

Test Plan:
- Reset check: rst_n low, then release with all req_valid=0 -> rsp_valid=0, rsp_data=0, req_ready=0, rf_sel=0.
- Single request: R5 holds 0x1234; requester 1 requests addr 5 -> req_ready=3'b010 and rf_sel=5 that cycle; next cycle rsp_valid=3'b010, rsp_data=0x1234.
- Round robin: all three requesters valid continuously for 6 cycles, pointer 0 at start -> grants 0,1,2,0,1,2; responses follow one cycle later with matching data.
- Write forwarding: requester 0 reads R7 (stored value 0x00AA) while wr_en=1, wr_addr=7, wr_data=0xBEEF -> rsp_data=0xBEEF. With wr_addr=6 instead -> rsp_data=0x00AA.
- R0 rule: ZERO_R0=1, read addr 0 with rf_rdata=0xFFFF and a forwarded write of 0x5555 to R0 -> rsp_data=0x0000.
- Stall and mid-operation reset: port_en=0 for 2 cycles with requester 2 valid -> req_ready=0 and pointer unchanged. Then grant requester 2 and assert rst_n low in the following cycle -> rsp_valid stays 0 and the pointer reads 0 after release.
